// File: rtl/la_vectorlib_pkg.sv
// la_vectorlib_pkg: shared width helpers for the la_vector block family
package la_vectorlib_pkg;
  function automatic int ptr_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/la_rrarb.sv
// la_rrarb: combinational rotate-priority one-hot arbiter, ptr is the highest-priority index
module la_rrarb
  import la_vectorlib_pkg::*;
#(
  parameter int M  = 4,
  parameter int PW = ptr_w(M)
) (
  input  logic [M-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [M-1:0]  grant
);
  logic [M-1:0] w_rot;
  logic [M-1:0] w_pick;
  // rotate so ptr sits at bit 0, keep the lowest set bit, rotate back
  always_comb begin
    w_rot  = M'({req, req} >> ptr);
    w_pick = w_rot & (~w_rot + M'(1));
    grant  = M'(({w_pick, w_pick} << ptr) >> M);
  end
endmodule

// File: rtl/la_vmuxrr.sv
// la_vmuxrr: M-input round-robin arbitrated vector mux with registered output and optional packet lock
module la_vmuxrr
  import la_vectorlib_pkg::*;
#(
  parameter int N    = 1,
  parameter int M    = 4,
  parameter int LOCK = 0,
  parameter     PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M*N-1:0] in,
  input  logic [M-1:0] in_valid,
  input  logic [M-1:0] in_last,
  output logic [M-1:0] in_ready,
  output logic [N-1:0] out,
  output logic         out_valid,
  output logic         out_last,
  output logic [M-1:0] out_sel,
  input  logic         out_ready
);
  localparam int PW = ptr_w(M);
  logic [PW-1:0] r_ptr;
  logic          r_lock;
  logic [M-1:0]  r_lsel;
  logic [M-1:0]  w_arb;
  logic [M-1:0]  w_grant;
  logic [PW-1:0] w_nptr;
  logic [N-1:0]  w_data;
  logic          w_accept;
  logic          w_xfer;
  logic          w_last;
  la_rrarb #(.M(M), .PW(PW)) u_arb (
    .req   (in_valid),
    .ptr   (r_ptr),
    .grant (w_arb)
  );
  // grant (locked channel only while a packet is open), handshake and one-hot AND-OR select
  always_comb begin
    w_grant  = r_lock ? (r_lsel & in_valid) : w_arb;
    w_accept = ~reset & (~out_valid | out_ready);
    in_ready = w_grant & {M{w_accept}};
    w_xfer   = |in_ready;
    w_last   = |(w_grant & in_last);
    w_data   = '0;
    w_nptr   = '0;
    for (int i = 0; i < M; i++) begin
      w_data = w_data | (in[i*N +: N] & {N{w_grant[i]}});
      w_nptr = w_grant[i] ? PW'((i + 1) % M) : w_nptr;
    end
  end
  // output register, priority pointer and packet lock
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sel   <= '0;
      r_ptr     <= '0;
      r_lock    <= 1'b0;
      r_lsel    <= '0;
    end else if (w_xfer) begin
      out       <= w_data;
      out_last  <= w_last;
      out_sel   <= w_grant;
      out_valid <= 1'b1;
      r_ptr     <= w_nptr;
      r_lock    <= (LOCK != 0) & ~w_last;
      r_lsel    <= w_grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_la_vmuxrr.sv
// tb_la_vmuxrr: directed and random checks of four la_vmuxrr builds against a behavioural model
module tb_la_vmuxrr;
  logic        clk;
  logic        reset;
  logic [39:0] din;
  logic [4:0]  v;
  logic [4:0]  l;
  logic        ordy;
  logic [3:0]  r0, r1, s0, s1;
  logic        r2, s2;
  logic [4:0]  r3, s3;
  logic [7:0]  od [4];
  logic [3:0]  ovv, olv;
  logic [4:0]  rdy [4];
  logic [4:0]  os [4];
  int checks = 0;
  int errors = 0;
  int          mm    [4] = '{4, 4, 1, 5};
  int          mlock [4] = '{0, 1, 0, 0};
  int          mptr  [4];
  int          mlk   [4];
  int          mg    [4];
  logic        mov   [4];
  logic [7:0]  mdat  [4];
  logic        mol   [4];
  logic [4:0]  mos   [4];

  la_vmuxrr #(.N(8), .M(4), .LOCK(0)) u_d0 (.clk(clk), .reset(reset), .in(din[31:0]), .in_valid(v[3:0]),
    .in_last(l[3:0]), .in_ready(r0), .out(od[0]), .out_valid(ovv[0]), .out_last(olv[0]), .out_sel(s0), .out_ready(ordy));
  la_vmuxrr #(.N(8), .M(4), .LOCK(1)) u_d1 (.clk(clk), .reset(reset), .in(din[31:0]), .in_valid(v[3:0]),
    .in_last(l[3:0]), .in_ready(r1), .out(od[1]), .out_valid(ovv[1]), .out_last(olv[1]), .out_sel(s1), .out_ready(ordy));
  la_vmuxrr #(.N(8), .M(1), .LOCK(0)) u_d2 (.clk(clk), .reset(reset), .in(din[7:0]), .in_valid(v[0]),
    .in_last(l[0]), .in_ready(r2), .out(od[2]), .out_valid(ovv[2]), .out_last(olv[2]), .out_sel(s2), .out_ready(ordy));
  la_vmuxrr #(.N(8), .M(5), .LOCK(0)) u_d3 (.clk(clk), .reset(reset), .in(din), .in_valid(v),
    .in_last(l), .in_ready(r3), .out(od[3]), .out_valid(ovv[3]), .out_last(olv[3]), .out_sel(s3), .out_ready(ordy));

  assign rdy[0] = {1'b0, r0};
  assign rdy[1] = {1'b0, r1};
  assign rdy[2] = {4'b0, r2};
  assign rdy[3] = r3;
  assign os[0]  = {1'b0, s0};
  assign os[1]  = {1'b0, s1};
  assign os[2]  = {4'b0, s2};
  assign os[3]  = s3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  function automatic int gnt(input int d);
    int c;
    if (mlk[d] >= 0) return v[mlk[d]] ? mlk[d] : -1;
    for (int k = 0; k < mm[d]; k++) begin
      c = (mptr[d] + k) % mm[d];
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic mreset();
    for (int d = 0; d < 4; d++) begin
      mptr[d] = 0; mlk[d] = -1; mov[d] = 1'b0; mdat[d] = '0; mol[d] = 1'b0; mos[d] = '0;
    end
  endtask

  task automatic cyc();
    logic [4:0] er;
    #1;
    for (int d = 0; d < 4; d++) begin
      mg[d] = gnt(d);
      er = (!reset && mg[d] >= 0 && (!mov[d] || ordy)) ? 5'(1 << mg[d]) : 5'd0;
      chk($sformatf("in_ready%0d", d), rdy[d], er);
    end
    @(posedge clk);
    for (int d = 0; d < 4; d++) begin
      if (reset) begin
        mptr[d] = 0; mlk[d] = -1; mov[d] = 1'b0; mdat[d] = '0; mol[d] = 1'b0; mos[d] = '0;
      end else if (mg[d] >= 0 && (!mov[d] || ordy)) begin
        mdat[d] = din[mg[d]*8 +: 8];
        mol[d]  = l[mg[d]];
        mos[d]  = 5'(1 << mg[d]);
        mov[d]  = 1'b1;
        mptr[d] = (mg[d] + 1) % mm[d];
        if (mlock[d] != 0) mlk[d] = l[mg[d]] ? -1 : mg[d];
      end else if (ordy) begin
        mov[d] = 1'b0;
      end
    end
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("out_valid%0d", d), ovv[d], mov[d]);
      chk($sformatf("out%0d", d), od[d], mdat[d]);
      chk($sformatf("out_last%0d", d), olv[d], mol[d]);
      chk($sformatf("out_sel%0d", d), os[d], mos[d]);
    end
  endtask

  task automatic rnd();
    din  = 40'({$urandom(), $urandom()});
    v    = 5'($urandom());
    l    = 5'($urandom());
    ordy = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    mreset();
    reset = 1'b1;
    rnd();
    cyc();
    chk("rst_valid", ovv[0], 1'b0);
    chk("rst_out", od[0], 8'h00);
    chk("rst_sel", os[0], 5'b0);
    chk("rst_ready", rdy[0], 5'b0);
    rnd();
    cyc();
    reset = 1'b0;
    v = 5'b11111;
    l = 5'b0;
    ordy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      din = 40'({$urandom(), $urandom()});
      cyc();
      chk("fair_sel", os[0], 5'(1 << (k % 4)));
      chk("fair_valid", ovv[0], 1'b1);
    end
    ordy = 1'b0;
    v = 5'b01111;
    for (int k = 0; k < 3; k++) begin
      din = 40'({$urandom(), $urandom()});
      cyc();
      chk("bp_ready", rdy[0], 5'b0);
      chk("bp_sel", os[0], 5'b01000);
    end
    ordy = 1'b1;
    cyc();
    chk("bp_release_valid", ovv[0], 1'b1);
    chk("bp_release_sel", os[0], 5'b00001);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    v = 5'b00110;
    l = 5'b0;
    cyc();
    chk("lk_b1", os[1], 5'b00010);
    cyc();
    chk("lk_b2", os[1], 5'b00010);
    v = 5'b00100;
    cyc();
    chk("lk_gap_ready", rdy[1], 5'b0);
    chk("lk_gap_valid", ovv[1], 1'b0);
    v = 5'b00110;
    l = 5'b00010;
    cyc();
    chk("lk_b3", os[1], 5'b00010);
    chk("lk_b3_last", olv[1], 1'b1);
    v = 5'b00100;
    l = 5'b0;
    cyc();
    chk("lk_next", os[1], 5'b00100);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    v = 5'b00110;
    cyc();
    cyc();
    chk("rm_locked", os[1], 5'b00010);
    reset = 1'b1;
    cyc();
    chk("rm_drop", ovv[1], 1'b0);
    reset = 1'b0;
    v = 5'b00011;
    cyc();
    chk("rm_ch0", os[1], 5'b00001);
    for (int k = 0; k < 3000; k++) begin
      rnd();
      reset = ($urandom_range(0, 199) == 0);
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
